// File: rtl/execute_stage_pipe.sv
// rtl/execute_stage_pipe.sv - RISC-V execute stage with forwarding, branch resolution and iterative MUL
// Single-cycle ops load the output register on accept; MUL iterates in BUSY before loading it.
module execute_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int MUL_EN   = 1,
  parameter int MUL_BITS = 4
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     RD_Instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] RD1_Top,
  input  logic [XLEN-1:0] RD2_Top,
  input  logic [XLEN-1:0] Imm_Ext_Top,
  input  logic            mem_fwd_en,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     next_IR,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] next_RD2_Top,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);
  localparam int SHW   = $clog2(XLEN);
  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_mul_rs2;
  logic [31:0]     r_mul_ir;
  logic            r_out_valid;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_rd2;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_illegal;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1_a;
  logic [4:0]      w_rs2_a;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_opb;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_sum;
  logic            w_cond;
  logic            w_r_legal;
  logic [XLEN-1:0] w_result;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_illegal;
  logic            w_is_mul;
  logic            w_space;
  logic            w_accept;
  logic [XLEN-1:0] w_pp;
  logic            w_unused;

  assign w_opcode = RD_Instr[6:0];
  assign w_f3     = RD_Instr[14:12];
  assign w_f7     = RD_Instr[31:25];
  assign w_rs1_a  = RD_Instr[19:15];
  assign w_rs2_a  = RD_Instr[24:20];
  assign w_unused = ^RD_Instr[11:7];

  // Memory-stage data is younger than write-back data, so it wins; x0 is hardwired zero.
  always_comb begin
    w_rs1 = RD1_Top;
    if (w_rs1_a != 5'd0) begin
      if (mem_fwd_en && (mem_fwd_rd == w_rs1_a))     w_rs1 = mem_fwd_data;
      else if (wb_fwd_en && (wb_fwd_rd == w_rs1_a))  w_rs1 = wb_fwd_data;
    end
  end

  always_comb begin
    w_rs2 = RD2_Top;
    if (w_rs2_a != 5'd0) begin
      if (mem_fwd_en && (mem_fwd_rd == w_rs2_a))     w_rs2 = mem_fwd_data;
      else if (wb_fwd_en && (wb_fwd_rd == w_rs2_a))  w_rs2 = wb_fwd_data;
    end
  end

  assign w_opb   = (w_opcode == OP_R) ? w_rs2 : Imm_Ext_Top;
  assign w_shamt = w_opb[SHW-1:0];
  assign w_sum   = w_rs1 + Imm_Ext_Top;

  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'b000: w_alu = ((w_opcode == OP_R) && w_f7[5]) ? (w_rs1 - w_opb) : (w_rs1 + w_opb);
      3'b001: w_alu = w_rs1 << w_shamt;
      3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_rs1) < $signed(w_opb))};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, (w_rs1 < w_opb)};
      3'b100: w_alu = w_rs1 ^ w_opb;
      3'b101: w_alu = w_f7[5] ? $unsigned($signed(w_rs1) >>> w_shamt) : (w_rs1 >> w_shamt);
      3'b110: w_alu = w_rs1 | w_opb;
      3'b111: w_alu = w_rs1 & w_opb;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (w_f3)
      3'b000: w_cond = (w_rs1 == w_rs2);
      3'b001: w_cond = (w_rs1 != w_rs2);
      3'b100: w_cond = ($signed(w_rs1) < $signed(w_rs2));
      3'b101: w_cond = !($signed(w_rs1) < $signed(w_rs2));
      3'b110: w_cond = (w_rs1 < w_rs2);
      3'b111: w_cond = !(w_rs1 < w_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  // Only base encodings are legal in R-type; funct7=0000001 is reserved for MUL alone.
  assign w_r_legal = (w_f7 == 7'b0000000) ||
                     ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));

  always_comb begin
    w_result  = '0;
    w_taken   = 1'b0;
    w_target  = '0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (w_opcode)
      OP_R: begin
        if ((w_f7 == 7'b0000001) && (w_f3 == 3'b000)) begin
          if (MUL_EN != 0) w_is_mul  = 1'b1;
          else             w_illegal = 1'b1;
        end else if (w_r_legal) begin
          w_result = w_alu;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_I:               w_result = w_alu;
      OP_LOAD, OP_STORE:  w_result = w_sum;
      OP_BRANCH: begin
        w_taken  = w_cond;
        w_target = pc + Imm_Ext_Top;
      end
      OP_JAL: begin
        w_result = pc + XLEN'(4);
        w_taken  = 1'b1;
        w_target = pc + Imm_Ext_Top;
      end
      OP_JALR: begin
        w_result = pc + XLEN'(4);
        w_taken  = 1'b1;
        w_target = {w_sum[XLEN-1:1], 1'b0};
      end
      OP_LUI:   w_result = Imm_Ext_Top;
      OP_AUIPC: w_result = pc + Imm_Ext_Top;
      default:  w_illegal = 1'b1;
    endcase
  end

  assign w_space  = !r_out_valid || out_ready;
  assign in_ready = (r_state == S_IDLE) && !flush && w_space;
  assign w_accept = in_valid && in_ready;
  assign w_pp     = r_mcand * XLEN'(r_mplier[MUL_BITS-1:0]);

  // The last partial product is folded in on the same edge that loads the output register.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_mul_ir    <= '0;
      r_mul_rs2   <= '0;
      r_out_valid <= 1'b0;
      r_ir        <= '0;
      r_result    <= '0;
      r_rd2       <= '0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (w_is_mul) begin
            r_state   <= S_BUSY;
            r_count   <= CW'(STEPS);
            r_acc     <= '0;
            r_mcand   <= w_rs1;
            r_mplier  <= w_rs2;
            r_mul_ir  <= RD_Instr;
            r_mul_rs2 <= w_rs2;
          end else begin
            r_out_valid <= 1'b1;
            r_ir        <= RD_Instr;
            r_result    <= w_result;
            r_rd2       <= w_rs2;
            r_taken     <= w_taken;
            r_target    <= w_target;
            r_illegal   <= w_illegal;
          end
        end
      end else begin
        if (r_count != CW'(1)) begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << MUL_BITS;
          r_mplier <= r_mplier >> MUL_BITS;
          r_count  <= r_count - CW'(1);
        end else if (w_space) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b1;
          r_ir        <= r_mul_ir;
          r_result    <= r_acc + w_pp;
          r_rd2       <= r_mul_rs2;
          r_taken     <= 1'b0;
          r_target    <= '0;
          r_illegal   <= 1'b0;
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign next_IR       = r_ir;
  assign result        = r_result;
  assign next_RD2_Top  = r_rd2;
  assign branch_taken  = r_taken;
  assign branch_target = r_target;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb/tb_execute_stage_pipe.sv - scoreboard bench for execute_stage_pipe
// Directed cases plus randomized traffic checked against a mnemonic-level reference model.
module tb_execute_stage_pipe;
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst, flush, in_valid, out_ready, mem_fwd_en, wb_fwd_en;
  logic        in_ready, out_valid, branch_taken, illegal;
  logic [31:0] RD_Instr, pc, RD1_Top, RD2_Top, Imm_Ext_Top, mem_fwd_data, wb_fwd_data;
  logic [31:0] next_IR, result, next_RD2_Top, branch_target;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;

  execute_stage_pipe #(.XLEN(32), .MUL_EN(1), .MUL_BITS(4)) dut (
    .clk1(clk1), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RD_Instr(RD_Instr), .pc(pc), .RD1_Top(RD1_Top), .RD2_Top(RD2_Top), .Imm_Ext_Top(Imm_Ext_Top),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .next_IR(next_IR), .result(result),
    .next_RD2_Top(next_RD2_Top), .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] res;
    logic [31:0] rd2;
    logic        tk;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (mem_fwd_en && mem_fwd_rd == r) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == r) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic [31:0] sra32(input logic [31:0] x, input int sh);
    logic [63:0] t;
    t = {{32{x[31]}}, x} >> sh;
    return t[31:0];
  endfunction

  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm);
    exp_t        e;
    logic [31:0] y;
    int          sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3 = ir[14:12];
    f7 = ir[31:25];
    e = '0;
    e.ir = ir;
    e.rd2 = b;
    case (ir[6:0])
      7'h33, 7'h13: begin
        y  = (ir[6:0] == 7'h33) ? b : imm;
        sh = int'(y % 32);
        if (ir[6:0] == 7'h33 && f7 == 7'h01 && f3 == 3'd0) e.res = a * b;
        else begin
          case (f3)
            3'd0: e.res = (ir[6:0] == 7'h33 && f7 == 7'h20) ? a - y : a + y;
            3'd1: e.res = a << sh;
            3'd2: e.res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: e.res = (a < y) ? 32'd1 : 32'd0;
            3'd4: e.res = a ^ y;
            3'd5: e.res = f7[5] ? sra32(a, sh) : (a >> sh);
            3'd6: e.res = a | y;
            default: e.res = a & y;
          endcase
        end
      end
      7'h03, 7'h23: e.res = a + imm;
      7'h63: begin
        e.tgt = p + imm;
        case (f3)
          3'd0: e.tk = (a == b);
          3'd1: e.tk = (a != b);
          3'd4: e.tk = ($signed(a) < $signed(b));
          3'd5: e.tk = ($signed(a) >= $signed(b));
          3'd6: e.tk = (a < b);
          3'd7: e.tk = (a >= b);
          default: e.tk = 1'b0;
        endcase
      end
      7'h6f: begin e.res = p + 32'd4; e.tk = 1'b1; e.tgt = p + imm; end
      7'h67: begin e.res = p + 32'd4; e.tk = 1'b1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
      7'h37: e.res = imm;
      7'h17: e.res = p + imm;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
    int k;
    k  = $urandom_range(0, 11);
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    rd = 5'($urandom);
    f3 = 3'($urandom);
    f7 = 7'h00;
    case (k)
      0, 1: begin
        op = 7'h33;
        if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
      end
      2: begin op = 7'h33; f7 = 7'h01; f3 = 3'd0; end
      3: begin
        op = 7'h13;
        if (f3 == 3'd5 && $urandom_range(0, 1) == 1) f7 = 7'h20;
        else if (f3 != 3'd1 && f3 != 3'd5) f7 = 7'($urandom);
      end
      4: op = 7'h03;
      5: op = 7'h23;
      6: begin
        op = 7'h63;
        case ($urandom_range(0, 5))
          0: f3 = 3'd0;  1: f3 = 3'd1;  2: f3 = 3'd4;
          3: f3 = 3'd5;  4: f3 = 3'd6;  default: f3 = 3'd7;
        endcase
      end
      7: op = 7'h6f;
      8: op = 7'h67;
      9: op = 7'h37;
      10: op = 7'h17;
      default: begin
        case ($urandom_range(0, 3))
          0: op = 7'h00;  1: op = 7'h7f;  2: op = 7'h0f;  default: op = 7'h73;
        endcase
        f7 = 7'($urandom);
      end
    endcase
    return {f7, r2, r1, f3, rd, op};
  endfunction

  task automatic issue(input logic [31:0] ir, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, output int waits);
    RD_Instr = ir; pc = p; RD1_Top = a; RD2_Top = b; Imm_Ext_Top = imm; in_valid = 1'b1;
    waits = 0;
    @(negedge clk1);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk1);
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: actual in_ready 0 after %0d cycles, required 1", waits);
    end else begin
      sb.push_back(model(ir, p, fwd(ir[19:15], a), fwd(ir[24:20], b), imm));
    end
    @(posedge clk1); #1;
  endtask

  // Monitor: every visible output must match the oldest expected entry and stay put while stalled.
  always @(negedge clk1) begin
    if (rst && !flush && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: actual ir %h, required no output", next_IR);
      end else begin
        chk("next_IR", next_IR, sb[0].ir);
        chk("result", result, sb[0].res);
        chk("next_RD2_Top", next_RD2_Top, sb[0].rd2);
        chk("branch_taken", 32'(branch_taken), 32'(sb[0].tk));
        chk("branch_target", branch_target, sb[0].tgt);
        chk("illegal", 32'(illegal), 32'(sb[0].ill));
        if (!out_ready) chk("in_ready_stalled", 32'(in_ready), 32'd0);
        else void'(sb.pop_front());
      end
    end
  end

  localparam logic [31:0] ADD_IR  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] SUB_IR  = {7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] BLTU_IR = {7'h00, 5'd2, 5'd1, 3'd6, 5'd0, 7'h63};
  localparam logic [31:0] BLT_IR  = {7'h00, 5'd2, 5'd1, 3'd4, 5'd0, 7'h63};
  localparam logic [31:0] MUL_IR  = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};

  initial begin
    int w;
    int busy;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    RD_Instr = '0; pc = '0; RD1_Top = '0; RD2_Top = '0; Imm_Ext_Top = '0;
    mem_fwd_en = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_en = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    repeat (2) @(posedge clk1);
    #1;
    @(negedge clk1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_next_IR", next_IR, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd2", next_RD2_Top, 32'd0);
    chk("reset_taken", 32'(branch_taken), 32'd0);
    chk("reset_target", branch_target, 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    @(posedge clk1); #1;
    rst = 1'b1;

    issue(ADD_IR, 32'h0, 32'd5, 32'd7, 32'h0, w);
    in_valid = 1'b0;
    @(negedge clk1);
    chk("add_latency", 32'(out_valid), 32'd1);
    chk("add_result", result, 32'd12);
    chk("add_ir", next_IR, ADD_IR);

    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'd100;
    wb_fwd_en = 1'b1;  wb_fwd_rd = 5'd1;  wb_fwd_data = 32'd50;
    @(posedge clk1); #1;
    issue(SUB_IR, 32'h0, 32'd9, 32'd30, 32'h0, w);
    in_valid = 1'b0;
    @(negedge clk1);
    chk("sub_mem_fwd", result, 32'd70);
    mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
    @(posedge clk1); #1;
    issue(SUB_IR, 32'h0, 32'd9, 32'd30, 32'h0, w);
    in_valid = 1'b0;
    @(negedge clk1);
    chk("sub_no_fwd", result, 32'hFFFF_FFEB);
    mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
    @(posedge clk1); #1;

    issue(BLTU_IR, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, w);
    in_valid = 1'b0;
    @(negedge clk1);
    chk("bltu_taken", 32'(branch_taken), 32'd0);
    @(posedge clk1); #1;
    issue(BLT_IR, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, w);
    in_valid = 1'b0;
    @(negedge clk1);
    chk("blt_taken", 32'(branch_taken), 32'd1);
    chk("blt_target", branch_target, 32'h120);
    @(posedge clk1); #1;

    issue(MUL_IR, 32'h0, 32'hFFFF_FFFF, 32'd3, 32'h0, w);
    in_valid = 1'b0;
    busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk1);
      if (out_valid) break;
      if (!in_ready) busy++;
    end
    chk("mul_busy_cycles", 32'(busy), 32'd8);
    chk("mul_result", result, 32'hFFFF_FFFD);
    @(posedge clk1); #1;

    out_ready = 1'b0;
    issue(ADD_IR, 32'h0, 32'h11, 32'h22, 32'h0, w);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk1);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_result", result, 32'h33);
    end
    @(posedge clk1); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue({7'h00, 5'd2, 5'd1, 3'd0, 5'(k + 4), 7'h33}, 32'h0, 32'(k), 32'd1, 32'h0, w);
      chk("stream_no_wait", 32'(w), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk1);
    chk("stream_last_valid", 32'(out_valid), 32'd1);
    @(negedge clk1);
    chk("stream_drained", 32'(out_valid), 32'd0);
    @(posedge clk1); #1;

    issue(MUL_IR, 32'h0, 32'h1234, 32'h5678, 32'h0, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk1);
    #1 flush = 1'b1;
    @(negedge clk1);
    sb.delete();
    @(posedge clk1); #1;
    flush = 1'b0;
    @(negedge clk1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk1); #1;

    issue(ADD_IR, 32'h0, 32'd1, 32'd2, 32'h0, w);
    issue(BLT_IR, 32'h40, 32'd1, 32'd2, 32'h8, w);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk1);
    sb.delete();
    @(posedge clk1); #1;
    @(negedge clk1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_next_IR", next_IR, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_taken", 32'(branch_taken), 32'd0);
    chk("rst_target", branch_target, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk1); #1;
    rst = 1'b1;

    issue(32'h0000_0000, 32'h0, 32'd3, 32'd4, 32'h0, w);
    in_valid = 1'b0;
    @(negedge clk1);
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_result", result, 32'd0);
    chk("illegal_taken", 32'(branch_taken), 32'd0);
    @(posedge clk1); #1;

    for (int i = 0; i < 600; i++) begin
      in_valid     = ($urandom_range(0, 9) < 8);
      RD_Instr     = rand_ir();
      pc           = $urandom & 32'hFFFF_FFFC;
      RD1_Top      = $urandom;
      RD2_Top      = ($urandom_range(0, 3) == 0) ? RD1_Top : $urandom;
      Imm_Ext_Top  = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      mem_fwd_en   = 1'($urandom);
      mem_fwd_rd   = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      wb_fwd_en    = 1'($urandom);
      wb_fwd_rd    = 5'($urandom_range(0, 7));
      wb_fwd_data  = $urandom;
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      @(negedge clk1);
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(model(RD_Instr, pc, fwd(RD_Instr[19:15], RD1_Top),
                           fwd(RD_Instr[24:20], RD2_Top), Imm_Ext_Top));
      @(posedge clk1); #1;
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk1);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/execute_stage_pipe.md
# execute_stage_pipe

Parametrised execute stage for the RISC-V pipeline, placed between the decode/register-read stage and the memory stage. It extends the single-cycle execute register with a valid/ready handshake, forwarding from the memory and write-back stages, branch/jump resolution, a full RV32I ALU, and an optional iterative multiplier that makes MUL a multi-cycle operation. Results, the instruction word and store data are registered toward the memory stage exactly once per accepted instruction.

## Interface
Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- MUL_EN, 1, 1 implements MUL (low XLEN bits of the product); 0 treats MUL as illegal.
- MUL_BITS, 4, multiplier bits consumed per cycle; must divide XLEN.

Ports:
- clk1  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous kill of in-flight and output-register contents.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- RD_Instr  in  32  instruction word.
- pc  in  XLEN  instruction address.
- RD1_Top  in  XLEN  rs1 register-file data.
- RD2_Top  in  XLEN  rs2 register-file data.
- Imm_Ext_Top  in  XLEN  sign-extended immediate.
- mem_fwd_en, mem_fwd_rd[4:0], mem_fwd_data[XLEN]  in  forwarding source from the memory stage.
- wb_fwd_en, wb_fwd_rd[4:0], wb_fwd_data[XLEN]  in  forwarding source from the write-back stage.
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  downstream consumes this cycle.
- next_IR  out  32  registered instruction.
- result  out  XLEN  registered ALU, address, link or product value.
- next_RD2_Top  out  XLEN  registered forwarded rs2 (store data).
- branch_taken  out  1  registered redirect request; meaningful only when out_valid is 1.
- branch_target  out  XLEN  registered redirect address.
- illegal  out  1  registered unsupported-opcode flag.

## Operation
- Operand selection for rs1 = RD_Instr[19:15] and rs2 = RD_Instr[24:20]:
  - A memory-stage match wins over a write-back match.
  - Register x0 is never forwarded.
  - Otherwise RD1_Top/RD2_Top are used.
  - Operands are captured at accept; later forwarding changes do not affect an instruction already in flight.
- Decode uses opcode RD_Instr[6:0], funct3 RD_Instr[14:12] and funct7 RD_Instr[31:25]:
  - 0110011 (R-type): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. funct7[5] selects SUB/SRA. funct7=0000001 with funct3=000 selects MUL.
  - 0010011 (I-type ALU): same set with the immediate; shift amount is imm[log2(XLEN)-1:0]; SRAI is selected by funct7[5].
  - 0000011 (load) and 0100011 (store): result = rs1 + imm.
  - 1100011 (branch): BEQ, BNE, BLT, BGE, BLTU, BGEU. branch_taken = compare outcome; branch_target = pc + imm; result = 0.
  - 1101111 (JAL): result = pc + 4; branch_taken = 1; branch_target = pc + imm.
  - 1100111 (JALR): result = pc + 4; branch_taken = 1; branch_target = (rs1 + imm) with bit 0 cleared.
  - 0110111 (LUI): result = imm. 0010111 (AUIPC): result = pc + imm.
  - Any other opcode, or MUL when MUL_EN = 0: illegal = 1, result = 0, branch_taken = 0.
- Arithmetic wraps modulo 2^XLEN. SLT/BLT are signed; SLTU/BLTU are unsigned.
- FSM states:
  - IDLE: accepting. A single-cycle op loads the output register. A MUL goes to BUSY with count = XLEN/MUL_BITS.
  - BUSY: each cycle adds rs1_shifted × (MUL_BITS multiplier bits) into the accumulator and decrements count. When count reaches 1, the next edge loads the output register and returns to IDLE.
- in_ready = (state == IDLE) && !flush && (!out_valid || out_ready).
- The output register holds all fields stable while out_valid && !out_ready.
- If BUSY completes while the output register is full and stalled, the FSM waits in BUSY with count = 1 until space frees.

## Timing
- Reset (rst = 0 at an edge): state = IDLE, out_valid = 0, and next_IR, result, next_RD2_Top, branch_taken, branch_target and illegal are all 0.
- Single-cycle ops: accepted at edge N, out_valid = 1 after edge N; latency 1. Full throughput of one per cycle while out_ready = 1.
- MUL: accepted at edge N, out_valid = 1 after edge N + XLEN/MUL_BITS. in_ready = 0 throughout BUSY.
- Simultaneous out_ready and accept: the old entry leaves and the new entry loads on the same edge.
- flush = 1 at an edge: out_valid goes to 0, BUSY aborts to IDLE, and no instruction is accepted that cycle. Flush takes priority over completion.
- rst takes priority over flush and over everything else.

## Test plan
- ADD x3,x1,x2 with RD1_Top = 5, RD2_Top = 7, out_ready = 1 -> out_valid the next cycle, result = 12, next_IR = the instruction word.
- SUB x3,x1,x2 with mem_fwd (rd = 1, data = 100) and wb_fwd (rd = 1, data = 50), RD2_Top = 30 -> result = 70. Repeat with rd = 0 and RD1_Top = 9 -> result = -21.
- BLTU with rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x100, imm = 0x20 -> branch_taken = 0. BLT with the same operands -> branch_taken = 1, branch_target = 0x120.
- MUL with rs1 = 0xFFFFFFFF, rs2 = 3, XLEN = 32, MUL_BITS = 4 -> in_ready = 0 for 8 cycles, then result = 0xFFFFFFFD.
- out_ready held 0 for 3 cycles after an ADD -> all outputs stable, in_ready = 0. On release, a back-to-back stream of 4 ops -> 4 consecutive valid cycles in order.
- flush asserted mid-MUL, then rst = 0 mid-stream -> out_valid = 0, in_ready = 1 the next cycle, all outputs 0 after reset; opcode 0000000 -> illegal = 1.
